// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device command transmitter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StShift,
        StAck,
        StWaitIdle
    } state_e;

    // Device clock falling-edge numbers within one host-to-device frame.
    localparam logic [3:0] DATA_BITS   = 4'd8;
    localparam logic [3:0] PARITY_EDGE = 4'd9;
    localparam logic [3:0] STOP_EDGE   = 4'd10;
    localparam logic [3:0] ACK_EDGE    = 4'd11;

    localparam int unsigned DEF_INHIBIT_CYCLES = 10000;
    localparam int unsigned DEF_RTS_CYCLES     = 20;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1500000;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request / status handshake between the register block and the PS/2 transmitter.
interface ps2_host_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout_err
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout_err
    );

endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 pin plus a falling-edge detector.
module ps2_host_tx_sync_edge (
    input  logic hclk_i,
    input  logic hrst_i,
    input  logic pin_i,
    output logic sync_o,
    output logic fall_o
);

    // [0],[1] synchronise; [2] holds the previous synchronised value.
    logic [2:0] shift_q;

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            shift_q <= 3'b111;
        end else begin
            shift_q <= {shift_q[1:0], pin_i};
        end
    end

    assign sync_o = shift_q[1];
    assign fall_o = shift_q[2] & ~shift_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned RTS_CYCLES     = DEF_RTS_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic hclk_i,
    input  logic hrst_i,
    ps2_host_tx_if.slave tx,
    input  logic ps2_clk_i,
    output logic ps2_clk_o,
    output logic ps2_clk_oen_o,
    input  logic ps2_dat_i,
    output logic ps2_dat_o,
    output logic ps2_dat_oen_o
);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;
    logic        clk_oen_q, clk_oen_d;
    logic        dat_oen_q, dat_oen_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic        timeout_q, timeout_d;

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;
    logic dev_state;

    ps2_host_tx_sync_edge u_clk_sync (
        .hclk_i (hclk_i),
        .hrst_i (hrst_i),
        .pin_i  (ps2_clk_i),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_host_tx_sync_edge u_dat_sync (
        .hclk_i (hclk_i),
        .hrst_i (hrst_i),
        .pin_i  (ps2_dat_i),
        .sync_o (dat_sync),
        .fall_o (dat_fall_unused)
    );

    // States where progress depends on the device and the timeout is armed.
    assign dev_state = state_q inside {StShift, StAck, StWaitIdle};

    always_ff @(posedge hclk_i) begin
        if (hrst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            clk_oen_q <= 1'b1;
            dat_oen_q <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            clk_oen_q <= clk_oen_d;
            dat_oen_q <= dat_oen_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        parity_d  = parity_q;
        clk_oen_d = clk_oen_q;
        dat_oen_d = dat_oen_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;

        if (dev_state) begin
            cnt_d = clk_fall ? '0 : cnt_q + 32'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (tx.tx_valid) begin
                    data_d    = tx.tx_data;
                    parity_d  = odd_parity(tx.tx_data);
                    clk_oen_d = 1'b0;
                    dat_oen_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == INHIBIT_CYCLES - 1) begin
                    cnt_d     = '0;
                    dat_oen_d = 1'b0;
                    state_d   = StRts;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRts: begin
                if (cnt_q == RTS_CYCLES - 1) begin
                    cnt_d     = '0;
                    clk_oen_d = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StShift: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_d <= DATA_BITS) begin
                        dat_oen_d = data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_d == PARITY_EDGE) begin
                        dat_oen_d = parity_q;
                    end else if (bit_cnt_d == STOP_EDGE) begin
                        dat_oen_d = 1'b1;
                        state_d   = StAck;
                    end
                end
            end
            StAck: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_d == ACK_EDGE) begin
                        if (dat_sync) begin
                            ack_err_d = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            state_d = StWaitIdle;
                        end
                    end
                end
            end
            StWaitIdle: begin
                if (clk_sync && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A device that stalls in place for the full budget gets its lines released.
        if (dev_state && state_d == state_q && cnt_d == TIMEOUT_CYCLES) begin
            clk_oen_d = 1'b1;
            dat_oen_d = 1'b1;
            timeout_d = 1'b1;
            state_d   = StIdle;
        end
    end

    assign tx.tx_ready    = (state_q == StIdle);
    assign tx.busy        = (state_q != StIdle);
    assign tx.done        = done_q;
    assign tx.ack_err     = ack_err_q;
    assign tx.timeout_err = timeout_q;

    assign ps2_clk_o     = 1'b0;
    assign ps2_dat_o     = 1'b0;
    assign ps2_clk_oen_o = clk_oen_q;
    assign ps2_dat_oen_o = dat_oen_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter. It sends one byte (e.g. 0xF4 "enable data reporting", 0xFF "reset") to a mouse or keyboard.
- Counterpart of the device-to-host frame receiver. Shares the same open-drain ps2_clk/ps2_dat pins.
- Sits behind the APB4 register block: software writes a byte, this block runs inhibit, request-to-send, 11 device-clocked bits and ACK check, then reports done or error.

Parameters:
- INHIBIT_CYCLES, 10000, hclk cycles the clock line is held low before request-to-send (100 us @ 100 MHz).
- RTS_CYCLES, 20, hclk cycles data is held low before the clock line is released.
- TIMEOUT_CYCLES, 1500000, maximum hclk cycles spent waiting in any device-driven state (15 ms @ 100 MHz).

Ports:
- hclk_i  in  1  system clock
- hrst_i  in  1  synchronous reset, active-high
- tx_valid_i  in  1  byte request
- tx_data_i  in  8  byte to send
- tx_ready_o  out  1  high only in IDLE; transfer accepted when valid&ready
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, byte sent and ACKed
- ack_err_o  out  1  one-cycle pulse, device did not ACK
- timeout_err_o  out  1  one-cycle pulse, device clock timeout
- ps2_clk_i  in  1  clock pin input (async)
- ps2_clk_o  out  1  constant 0
- ps2_clk_oen_o  out  1  0 = drive clock low, 1 = release
- ps2_dat_i  in  1  data pin input (async)
- ps2_dat_o  out  1  constant 0
- ps2_dat_oen_o  out  1  0 = drive data low, 1 = release

Behaviour:
- Reset is synchronous and active-high; the single clock is hclk_i.
- Reset values: state IDLE, clk_oen=1, dat_oen=1, tx_ready=1, busy=0, all pulses 0. Reset mid-transfer releases both lines on the next edge; no pulse is emitted.
- Synchronisers: ps2_clk_i and ps2_dat_i each pass through 2 flops. A falling edge is prev_sync=1 & cur_sync=0 (3-stage shift). Logic uses synchronised values only.
- Accept: on valid&ready, latch the byte and compute parity = ~^data (odd parity). Go to INHIBIT.
- INHIBIT: clk_oen=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
- RTS: clk_oen=0 and dat_oen=0 (start bit 0) for RTS_CYCLES cycles. Then clk_oen=1 and go to SHIFT with bit_cnt=0.
- SHIFT: on each synced falling edge, bit_cnt increments and the data line is set as follows:
  - Edges 1..8: dat_oen = data[edge-1] (a 1 bit releases the line, a 0 bit drives it low). LSB first.
  - Edge 9: dat_oen = parity.
  - Edge 10: dat_oen=1 (stop bit), go to ACK.
- ACK: on falling edge 11, sample synced data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: pulse ack_err_o, go to IDLE.
- WAIT_IDLE: when synced clk=1 and dat=1, pulse done_o and go to IDLE. done_o is asserted in the cycle IDLE is entered.
- Timeout: one counter, cleared on entry to SHIFT/ACK/WAIT_IDLE and on every falling edge. If it reaches TIMEOUT_CYCLES in one of those states: both oen=1, pulse timeout_err_o, go to IDLE.
- Error and done pulses are mutually exclusive; each lasts exactly 1 cycle.
- tx_valid_i while busy is ignored: no queuing, byte not latched. A request in the cycle a pulse is emitted is accepted, since ready is already 1.
- A falling edge arriving during INHIBIT/RTS is ignored (device glitch).
- clk_oen and dat_oen are registered outputs, so there are no combinational glitches on the pins.

Decomposition:
- ps2_pkg holds: state enum (IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE), the bit-count constants (DATA_BITS=8, PARITY_EDGE=9, STOP_EDGE=10, ACK_EDGE=11), and the default cycle constants.
- Sub-module ps2_sync_edge: 2-flop synchroniser plus falling-edge detector. Instantiated twice here; reusable by the receiver.

Test Plan:
- Send 0xF4, device model ACKs → bits driven on edges 1..8 are 0,0,1,0,1,1,1,1, parity 0, stop released. done_o pulses once and tx_ready_o returns to 1.
- Send 0xFF then 0x00 back-to-back, valid held high → parity 1 for both. The second byte is accepted only after the first done_o. Clock inhibit low for exactly INHIBIT_CYCLES each time.
- NACK: device leaves data high at edge 11 when sending 0x55 → ack_err_o single pulse, no done_o, both oen=1.
- Device never clocks after RTS → timeout_err_o exactly TIMEOUT_CYCLES cycles after SHIFT entry, lines released. Also: device stops after edge 4 → timeout.
- hrst_i asserted 1 cycle after edge 3 of 0xA5 → next cycle both oen=1, busy=0, no pulses. A new send of 0xA5 then completes normally.
- tx_valid_i pulsed with 0x12 during a 0xF4 transfer → ignored: only 0xF4 bits are seen on the wire, and one done_o.
